// File: rtl/msdap_pkg.sv
// msdap_pkg: shared widths and serializer state encoding for the MSDAP datapath.
package msdap_pkg;
  localparam int ACC_W = 40;
  localparam int CNT_W = 6;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} p2s_state_e;
endpackage

// File: rtl/alu_p2s_if.sv
// alu_p2s_if: capture request/data from the accumulator and serial stream back out.
interface alu_p2s_if #(parameter int W = 40);
  logic         p2s_en;
  logic [W-1:0] cap_data;
  logic         serial_out;
  logic         frame;
  logic         out_ready;
  modport master (output p2s_en, cap_data, input serial_out, frame, out_ready);
  modport slave  (input p2s_en, cap_data, output serial_out, frame, out_ready);
endinterface

// File: rtl/alu_p2s_shifter.sv
// p2s_shifter: captures a word and streams it MSB first with frame/out_ready.
module p2s_shifter
  import msdap_pkg::*;
#(
  parameter int W = 40
) (
  input logic    Sclk,
  input logic    Clear,
  alu_p2s_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);
  p2s_state_e       state_q, state_d;
  logic [W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             so_q, so_d, frame_q, frame_d, rdy_q, rdy_d;
  // A new capture always wins, so a request mid-word restarts the stream.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (bus.p2s_en) begin
      state_d = SHIFT;
      sr_d    = bus.cap_data;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      sr_d    = sr_q << 1;
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = (cnt_q == LAST) ? IDLE : SHIFT;
    end
    so_d    = (state_d == SHIFT) ? sr_d[W-1] : 1'b0;
    frame_d = (state_d == SHIFT) && (cnt_d == '0);
    rdy_d   = (state_d == SHIFT);
  end
  always_ff @(posedge Sclk) begin
    if (Clear) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      frame_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      frame_q <= frame_d;
      rdy_q   <= rdy_d;
    end
  end
  assign bus.serial_out = so_q;
  assign bus.frame      = frame_q;
  assign bus.out_ready  = rdy_q;
endmodule

// File: rtl/alu_p2s.sv
// alu_p2s: 40-bit add/sub/shift accumulator feeding a parallel-to-serial output stage.
module alu_p2s
  import msdap_pkg::*;
#(
  parameter int ACC_W = msdap_pkg::ACC_W
) (
  input  logic             Sclk,
  input  logic             Clear,
  input  logic [ACC_W-1:0] add_input,
  input  logic             addsub,
  input  logic             adder_en,
  input  logic             shift_en,
  input  logic             load,
  input  logic             clear,
  input  logic             p2s_en,
  output logic [ACC_W-1:0] acc_out,
  output logic             serial_out,
  output logic             frame,
  output logic             out_ready
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             op;
  alu_p2s_if #(.W(ACC_W)) p2s_bus ();
  assign op = load & adder_en;
  always_comb begin
    acc_d = clear ? '0
          : (op & shift_en) ? ACC_W'($signed(acc_q) >>> 1)
          : op ? (addsub ? acc_q - add_input : acc_q + add_input)
          : acc_q;
  end
  always_ff @(posedge Sclk) begin
    if (Clear) acc_q <= '0;
    else       acc_q <= acc_d;
  end
  // The shifter sees the pre-update accumulator, so capture+clear keeps the old word.
  assign p2s_bus.p2s_en   = p2s_en;
  assign p2s_bus.cap_data = acc_q;
  p2s_shifter #(.W(ACC_W)) u_shifter (
    .Sclk  (Sclk),
    .Clear (Clear),
    .bus   (p2s_bus.slave)
  );
  assign acc_out    = acc_q;
  assign serial_out = p2s_bus.serial_out;
  assign frame      = p2s_bus.frame;
  assign out_ready  = p2s_bus.out_ready;
endmodule

// File: tb/tb_alu_p2s.sv
// tb_alu_p2s: directed self-checking bench for the accumulator and serializer.
module tb_alu_p2s;
  logic Sclk = 1'b0;
  logic Clear, addsub, adder_en, shift_en, load, clear;
  logic [39:0] add_input, acc_out;
  int total = 0;
  int bad = 0;
  alu_p2s_if #(.W(40)) bus ();
  always #5 Sclk = ~Sclk;

  alu_p2s dut (
    .Sclk       (Sclk),
    .Clear      (Clear),
    .add_input  (add_input),
    .addsub     (addsub),
    .adder_en   (adder_en),
    .shift_en   (shift_en),
    .load       (load),
    .clear      (clear),
    .p2s_en     (bus.p2s_en),
    .acc_out    (acc_out),
    .serial_out (bus.serial_out),
    .frame      (bus.frame),
    .out_ready  (bus.out_ready)
  );

  task automatic cyc();
    @(posedge Sclk);
    @(negedge Sclk);
  endtask

  task automatic op(input logic ld, en, sh, sub, input logic [39:0] v);
    load = ld; adder_en = en; shift_en = sh; addsub = sub; add_input = v;
    cyc();
    load = 0; adder_en = 0; shift_en = 0; addsub = 0; add_input = '0;
  endtask

  task automatic set_acc(input logic [39:0] v);
    clear = 1; cyc(); clear = 0;
    op(1, 1, 0, 0, v);
  endtask

  task automatic recv(input int n, output logic [39:0] w, output int frames, output int rdys, output logic first_frame);
    w = '0; frames = 0; rdys = 0; first_frame = bus.frame;
    for (int i = 0; i < n; i++) begin
      w = {w[38:0], bus.serial_out};
      frames += int'(bus.frame);
      rdys += int'(bus.out_ready);
      cyc();
    end
  endtask

  task automatic test_reset();
    Clear = 1; cyc();
    total++;
    if ({acc_out, bus.serial_out, bus.frame, bus.out_ready} !== 43'd0) begin
      bad++; $display("FAIL reset: acc=%h so=%b fr=%b rdy=%b required all 0", acc_out, bus.serial_out, bus.frame, bus.out_ready);
    end
    Clear = 0; cyc();
    total++;
    if (acc_out !== 40'd0 || bus.out_ready !== 1'b0) begin
      bad++; $display("FAIL reset_release: acc=%h rdy=%b required 0/0", acc_out, bus.out_ready);
    end
  endtask

  task automatic test_accumulate();
    clear = 1; cyc(); clear = 0;
    op(1, 1, 0, 0, 40'h0000100000);
    total++;
    if (acc_out !== 40'h0000100000) begin bad++; $display("FAIL add1: acc=%h required 0000100000", acc_out); end
    op(1, 1, 0, 0, 40'h0000100000);
    op(1, 1, 0, 0, 40'h0000100000);
    total++;
    if (acc_out !== 40'h0000300000) begin bad++; $display("FAIL add3: acc=%h required 0000300000", acc_out); end
    op(0, 1, 0, 0, 40'h0000100000);
    total++;
    if (acc_out !== 40'h0000300000) begin bad++; $display("FAIL hold_noload: acc=%h required 0000300000", acc_out); end
  endtask

  task automatic test_sub_shift();
    set_acc(40'h0000010000);
    op(1, 1, 0, 1, 40'h0000030000);
    total++;
    if (acc_out !== 40'hFFFFFE0000) begin bad++; $display("FAIL sub: acc=%h required fffffe0000", acc_out); end
    op(1, 1, 1, 1, 40'h0000030000);
    total++;
    if (acc_out !== 40'hFFFFFF0000) begin bad++; $display("FAIL ashr: acc=%h required ffffff0000", acc_out); end
    op(1, 1, 0, 0, 40'h0000010000);
    total++;
    if (acc_out !== 40'h0) begin bad++; $display("FAIL wrap: acc=%h required 0000000000", acc_out); end
  endtask

  task automatic test_serialize();
    logic [39:0] w; int fr, rd; logic ff;
    set_acc(40'h8000000001);
    bus.p2s_en = 1; cyc(); bus.p2s_en = 0;
    total++;
    if (bus.frame !== 1'b1 || bus.serial_out !== 1'b1 || bus.out_ready !== 1'b1) begin
      bad++; $display("FAIL ser_first: fr=%b so=%b rdy=%b required 1/1/1", bus.frame, bus.serial_out, bus.out_ready);
    end
    recv(40, w, fr, rd, ff);
    total++;
    if (w !== 40'h8000000001) begin bad++; $display("FAIL ser_word: got=%h required 8000000001", w); end
    total++;
    if (fr !== 1 || rd !== 40) begin bad++; $display("FAIL ser_counts: frames=%0d ready=%0d required 1/40", fr, rd); end
    total++;
    if (bus.out_ready !== 1'b0 || bus.serial_out !== 1'b0 || bus.frame !== 1'b0) begin
      bad++; $display("FAIL ser_end: rdy=%b so=%b fr=%b required 0/0/0", bus.out_ready, bus.serial_out, bus.frame);
    end
  endtask

  task automatic test_simultaneous();
    logic [39:0] w; int fr, rd; logic ff;
    set_acc(40'h123456789A);
    bus.p2s_en = 1; clear = 1; cyc(); bus.p2s_en = 0; clear = 0;
    total++;
    if (acc_out !== 40'h0) begin bad++; $display("FAIL sim_acc: acc=%h required 0000000000", acc_out); end
    recv(40, w, fr, rd, ff);
    total++;
    if (w !== 40'h123456789A || ff !== 1'b1) begin bad++; $display("FAIL sim_word: got=%h frame0=%b required 123456789a/1", w, ff); end
  endtask

  task automatic test_restart();
    logic [39:0] w, part; int fr, rd; logic ff;
    set_acc(40'hA50F0F3C3C);
    bus.p2s_en = 1; cyc(); bus.p2s_en = 0;
    part = '0;
    for (int i = 0; i < 20; i++) begin
      part = {part[38:0], bus.serial_out};
      clear = (i == 0);
      load = (i == 1); adder_en = (i == 1); add_input = (i == 1) ? 40'h5AC3E1F00F : 40'h0;
      cyc();
    end
    clear = 0; load = 0; adder_en = 0; add_input = '0;
    total++;
    if (part[19:0] !== 20'hA50F0) begin bad++; $display("FAIL rst_partial: got=%h required a50f0", part[19:0]); end
    bus.p2s_en = 1; cyc(); bus.p2s_en = 0;
    recv(40, w, fr, rd, ff);
    total++;
    if (w !== 40'h5AC3E1F00F || ff !== 1'b1 || fr !== 1 || rd !== 40) begin
      bad++; $display("FAIL restart: got=%h frame0=%b frames=%0d ready=%0d required 5ac3e1f00f/1/1/40", w, ff, fr, rd);
    end
    total++;
    if (bus.out_ready !== 1'b0) begin bad++; $display("FAIL restart_end: rdy=%b required 0", bus.out_ready); end
  endtask

  task automatic test_reset_mid();
    logic [39:0] w; int fr, rd; logic ff;
    set_acc(40'h0);
    op(1, 1, 0, 1, 40'h1);
    bus.p2s_en = 1; cyc(); bus.p2s_en = 0;
    recv(10, w, fr, rd, ff);
    total++;
    if (w[9:0] !== 10'h3FF || rd !== 10) begin bad++; $display("FAIL mid_pre: bits=%h ready=%0d required 3ff/10", w[9:0], rd); end
    Clear = 1; cyc(); Clear = 0;
    total++;
    if ({acc_out, bus.serial_out, bus.frame, bus.out_ready} !== 43'd0) begin
      bad++; $display("FAIL mid_clear: acc=%h so=%b fr=%b rdy=%b required all 0", acc_out, bus.serial_out, bus.frame, bus.out_ready);
    end
    recv(5, w, fr, rd, ff);
    total++;
    if (w[4:0] !== 5'd0 || rd !== 0 || fr !== 0 || acc_out !== 40'd0) begin
      bad++; $display("FAIL mid_idle: bits=%h ready=%0d frames=%0d acc=%h required 0/0/0/0", w[4:0], rd, fr, acc_out);
    end
  endtask

  initial begin
    Clear = 1; addsub = 0; adder_en = 0; shift_en = 0; load = 0; clear = 0;
    add_input = '0; bus.p2s_en = 0;
    test_reset();
    test_accumulate();
    test_sub_shift();
    test_serialize();
    test_simultaneous();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
